// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV32I control FSM:
//   - state_t  : FSM state encoding (also exported on state_o for debug)
//   - OP_*     : major opcodes understood by the controller
//   - ALU_*    : fixed ALU operations used for address and branch compares
//   - iclass_t : instruction class derived from opcode/funct3
//   - classify : decodes an instruction word into its class
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEMORY     = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_TRAP       = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_BR  = 3'd4,
    C_ILL = 3'd5
  } iclass_t;

  // Loads/stores are word-only and branches are BEQ/BNE only; every other
  // funct3 under those opcodes is treated as illegal.
  function automatic iclass_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    iclass_t c;
    c = C_ILL;
    case (opcode)
      OP_R:    c = C_R;
      OP_I:    c = C_I;
      OP_LW:   if (funct3 == 3'b010) c = C_LW;
      OP_SW:   if (funct3 == 3'b010) c = C_SW;
      OP_BR:   if (funct3[2:1] == 2'b00) c = C_BR;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Counts wait cycles of a memory handshake. One instance serves both the
// instruction fetch wait and the data memory wait, since only one of them
// can be in progress at a time and the count clears on every state change.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear (highest priority after reset)
//   en         : count one more wait cycle
//   load       : load load_val into the counter
//   load_val   : value for load
//   count      : current wait count
//   expired    : the next counted cycle would reach LIMIT
// ---------------------------------------------------------------------------
module wait_timer #(
  parameter int LIMIT = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Flag one cycle early so the FSM can leave on the edge where the count
  // would reach LIMIT; a handshake in that same cycle still wins.
  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_hs
// Multicycle RV32I control FSM with ready/valid handshakes to the
// instruction and data memories, wait timeouts, BEQ/BNE resolution, an
// illegal-instruction trap with a sticky fault state, and a retired
// instruction counter.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   instr         : instruction currently held in the datapath IR
//   iReady        : instruction memory data valid this cycle
//   dReady        : data memory access completes this cycle
//   Zero          : ALU zero flag
//   irWrite       : latch instr into IR
//   PCSrc         : 0 = PC+4, 1 = branch target
//   loadPC        : PC update strobe
//   ALUSrc        : 1 = immediate operand
//   ALUCtrl       : ALU operation
//   RegWrite      : register file write enable
//   MemToReg      : writeback from data memory
//   MemRead       : data memory read request
//   MemWrite      : data memory write request
//   fault         : sticky trap indication
//   instret       : instructions retired (wraps)
//   state_o       : current FSM state
// ---------------------------------------------------------------------------
module multicycle_ctrl_hs
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUC_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              iReady,
  input  logic              dReady,
  input  logic              Zero,
  output logic              irWrite,
  output logic              PCSrc,
  output logic              loadPC,
  output logic              ALUSrc,
  output logic [ALUC_W-1:0] ALUCtrl,
  output logic              RegWrite,
  output logic              MemToReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              fault,
  output logic [CNT_W-1:0]  instret,
  output logic [2:0]        state_o
);

  localparam int TW = 8;

  state_t        state_reg;
  state_t        state_next;
  logic          retire;
  logic          timer_en;
  logic          timer_clr;
  logic          timer_expired;
  logic [TW-1:0] timer_count_unused;
  iclass_t       iclass;
  logic [2:0]    funct3;

  // Bits of the instruction word the controller never looks at.
  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  assign funct3 = instr[14:12];
  assign iclass = classify(instr[6:0], funct3);

  wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TW)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .en       (timer_en),
    .load     (1'b0),
    .load_val ('0),
    .count    (timer_count_unused),
    .expired  (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    timer_en   = 1'b0;
    irWrite    = 1'b0;
    PCSrc      = 1'b0;
    loadPC     = 1'b0;
    ALUSrc     = 1'b0;
    ALUCtrl    = '0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    fault      = 1'b0;

    case (state_reg)
      S_FETCH: begin
        irWrite = iReady;
        if (iReady) begin
          state_next = S_DECODE;
        end else begin
          timer_en = 1'b1;
          if (timer_expired) state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        state_next = (iclass == C_ILL) ? S_TRAP : S_EXECUTE;
      end

      S_EXECUTE: begin
        case (iclass)
          C_R: begin
            ALUCtrl    = ALUC_W'({instr[30], funct3});
            state_next = S_WRITE_BACK;
          end
          C_I: begin
            // Only the shift-right group uses instr[30] as an op modifier;
            // for other I-type ops that bit belongs to the immediate.
            ALUCtrl    = ALUC_W'({(funct3 == 3'b101) ? instr[30] : 1'b0, funct3});
            ALUSrc     = 1'b1;
            state_next = S_WRITE_BACK;
          end
          C_LW, C_SW: begin
            ALUCtrl    = ALUC_W'(ALU_ADD);
            ALUSrc     = 1'b1;
            state_next = S_MEMORY;
          end
          C_BR: begin
            ALUCtrl    = ALUC_W'(ALU_SUB);
            // funct3[0] distinguishes BNE from BEQ.
            PCSrc      = Zero ^ funct3[0];
            loadPC     = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_TRAP;
        endcase
      end

      S_MEMORY: begin
        if (iclass == C_LW || iclass == C_SW) begin
          MemRead  = (iclass == C_LW);
          MemWrite = (iclass == C_SW);
          if (dReady) begin
            if (iclass == C_LW) begin
              state_next = S_WRITE_BACK;
            end else begin
              loadPC     = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
          end else begin
            timer_en = 1'b1;
            if (timer_expired) state_next = S_TRAP;
          end
        end else begin
          // IR no longer holds a memory op; nothing sensible to complete.
          state_next = S_TRAP;
        end
      end

      S_WRITE_BACK: begin
        RegWrite   = 1'b1;
        MemToReg   = (instr[6:0] == OP_LW);
        loadPC     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: begin
        fault = 1'b1;
      end

      default: state_next = S_TRAP;
    endcase

    // Outputs are quiet for the whole time reset is applied, not just
    // after the first edge.
    if (rst) begin
      retire   = 1'b0;
      timer_en = 1'b0;
      irWrite  = 1'b0;
      PCSrc    = 1'b0;
      loadPC   = 1'b0;
      ALUSrc   = 1'b0;
      ALUCtrl  = '0;
      RegWrite = 1'b0;
      MemToReg = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      fault    = 1'b0;
    end
  end

  assign timer_clr = (state_next != state_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      instret   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_hs
// Directed stimulus for the multicycle controller. The driver pushes the
// hand-derived expected output vector for every cycle it drives; a separate
// monitor pops one entry per cycle on the falling edge and compares.
// The DUT is built with CNT_W = 4 so the retire counter wrap is reachable.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_hs;
  import ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   instr = '0;
  logic          iReady = 1'b0;
  logic          dReady = 1'b0;
  logic          Zero = 1'b0;
  logic          irWrite, PCSrc, loadPC, ALUSrc, RegWrite, MemToReg;
  logic          MemRead, MemWrite, fault;
  logic [3:0]    ALUCtrl;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  multicycle_ctrl_hs #(
    .CNT_W       (CW),
    .MEM_TIMEOUT (16),
    .ALUC_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .iReady   (iReady),
    .dReady   (dReady),
    .Zero     (Zero),
    .irWrite  (irWrite),
    .PCSrc    (PCSrc),
    .loadPC   (loadPC),
    .ALUSrc   (ALUSrc),
    .ALUCtrl  (ALUCtrl),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .fault    (fault),
    .instret  (instret),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Packed order: state, irWrite, PCSrc, loadPC, ALUSrc, ALUCtrl,
  //               RegWrite, MemToReg, MemRead, MemWrite, fault, instret
  logic [19:0] exp_q[$];
  string       name_q[$];
  logic [CW-1:0] model_ir = '0;

  logic [19:0] act;
  assign act = {state_o, irWrite, PCSrc, loadPC, ALUSrc, ALUCtrl,
                RegWrite, MemToReg, MemRead, MemWrite, fault, instret};

  logic [19:0] mon_e;
  string       mon_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      tests++;
      if (act !== mon_e) begin
        fails++;
        $display("FAIL %s: got %05h expected %05h (state %0d vs %0d)",
                 mon_n, act, mon_e, act[19:17], mon_e[19:17]);
      end
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] st, input logic irw, pcs, lpc, asrc,
                                     input logic [3:0] aluc, input logic rw, m2r, mr, mw, flt);
    return {st, irw, pcs, lpc, asrc, aluc, rw, m2r, mr, mw, flt};
  endfunction

  // Drives one cycle (called at posedge+1) and records its expected outputs.
  task automatic step(input string nm, input logic [31:0] ins, input logic ir, dr, z,
                      input logic [15:0] c, input logic ret);
    instr  = ins;
    iReady = ir;
    dReady = dr;
    Zero   = z;
    exp_q.push_back({c, model_ir});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (ret) model_ir = model_ir + 1'b1;
  endtask

  task automatic do_reset(input string nm);
    rst    = 1'b1;
    iReady = 1'b1;
    dReady = 1'b1;
    Zero   = 1'b1;
    #1;
    tests++;
    if (act !== 20'h0) begin
      fails++;
      $display("FAIL %s: got %05h expected 00000", nm, act);
    end
    model_ir = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] %s: reset applied", nm);
  endtask

  task automatic fetch(input string nm, input logic [31:0] ins, input int w);
    for (int i = 0; i < w; i++)
      step({nm, "_fwait"}, ins, 0, 0, 0, mk(S_FETCH, 0,0,0,0, 4'h0, 0,0,0,0,0), 0);
    step({nm, "_fetch"}, ins, 1, 0, 0, mk(S_FETCH, 1,0,0,0, 4'h0, 0,0,0,0,0), 0);
    step({nm, "_decode"}, ins, 1, 0, 0, mk(S_DECODE, 0,0,0,0, 4'h0, 0,0,0,0,0), 0);
  endtask

  task automatic run_alu(input string nm, input logic [31:0] ins, input int w,
                         input logic [3:0] aluc, input logic asrc);
    fetch(nm, ins, w);
    step({nm, "_ex"}, ins, 1, 1, 0, mk(S_EXECUTE, 0,0,0,asrc, aluc, 0,0,0,0,0), 0);
    step({nm, "_wb"}, ins, 1, 1, 0, mk(S_WRITE_BACK, 0,0,1,0, 4'h0, 1,0,0,0,0), 1);
    $display("[TB] %s issued", nm);
  endtask

  task automatic run_br(input string nm, input logic [31:0] ins, input logic z, input logic pcs);
    fetch(nm, ins, 0);
    step({nm, "_ex"}, ins, 1, 1, z, mk(S_EXECUTE, 0,pcs,1,0, ALU_SUB, 0,0,0,0,0), 1);
    $display("[TB] %s issued", nm);
  endtask

  task automatic run_lw(input string nm, input logic [31:0] ins, input int w);
    fetch(nm, ins, 0);
    step({nm, "_ex"}, ins, 1, 0, 0, mk(S_EXECUTE, 0,0,0,1, ALU_ADD, 0,0,0,0,0), 0);
    for (int i = 0; i < w; i++)
      step({nm, "_mwait"}, ins, 1, 0, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,1,0,0), 0);
    step({nm, "_mem"}, ins, 1, 1, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,1,0,0), 0);
    step({nm, "_wb"}, ins, 1, 0, 0, mk(S_WRITE_BACK, 0,0,1,0, 4'h0, 1,1,0,0,0), 1);
    $display("[TB] %s issued", nm);
  endtask

  task automatic run_sw(input string nm, input logic [31:0] ins, input int w);
    fetch(nm, ins, 0);
    step({nm, "_ex"}, ins, 1, 0, 0, mk(S_EXECUTE, 0,0,0,1, ALU_ADD, 0,0,0,0,0), 0);
    for (int i = 0; i < w; i++)
      step({nm, "_mwait"}, ins, 1, 0, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,0,1,0), 0);
    step({nm, "_mem"}, ins, 1, 1, 0, mk(S_MEMORY, 0,0,1,0, 4'h0, 0,0,0,1,0), 1);
    $display("[TB] %s issued", nm);
  endtask

  task automatic trap_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++)
      step({nm, "_trap"}, 32'h002081B3, 1, 1, 1, mk(S_TRAP, 0,0,0,0, 4'h0, 0,0,0,0,1), 0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4030D293;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_LB   = 32'h00800283;
  localparam logic [31:0] I_SW   = 32'h00502623;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  initial begin
    do_reset("reset");

    run_alu("add",  I_ADD,  0, 4'b0000, 0);
    run_alu("sub",  I_SUB,  2, 4'b1000, 0);
    run_alu("srai", I_SRAI, 0, 4'b1101, 1);
    run_alu("addi", I_ADDI, 0, 4'b0000, 1);
    run_lw("lw", I_LW, 3);
    run_sw("sw", I_SW, 0);
    run_br("beq_z1", I_BEQ, 1, 1);
    run_br("bne_z1", I_BNE, 1, 0);
    run_br("beq_z0", I_BEQ, 0, 0);

    // Illegal opcode: trap, stay there despite handshakes, cleared by rst.
    fetch("ill", I_ILL, 0);
    trap_cycles("ill", 4);
    do_reset("rst_after_trap");

    // LB is not supported: illegal funct3 under the load opcode.
    fetch("lb", I_LB, 0);
    trap_cycles("lb", 2);
    do_reset("rst_after_lb");

    // Store whose dReady never comes: 16 MEMORY cycles, then TRAP.
    fetch("sw_to", I_SW, 0);
    step("sw_to_ex", I_SW, 1, 0, 0, mk(S_EXECUTE, 0,0,0,1, ALU_ADD, 0,0,0,0,0), 0);
    for (int i = 0; i < 16; i++)
      step("sw_to_mwait", I_SW, 1, 0, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,0,1,0), 0);
    step("sw_to_trap", I_SW, 1, 0, 0, mk(S_TRAP, 0,0,0,0, 4'h0, 0,0,0,0,1), 0);
    do_reset("rst_after_sw_to");

    // dReady on the 16th MEMORY cycle: handshake wins over the timeout.
    run_sw("sw_late", I_SW, 15);

    // Fetch timeout: iReady never comes.
    do_reset("rst_before_fto");
    for (int i = 0; i < 16; i++)
      step("fto_fwait", I_ADD, 0, 0, 0, mk(S_FETCH, 0,0,0,0, 4'h0, 0,0,0,0,0), 0);
    step("fto_trap", I_ADD, 1, 0, 0, mk(S_TRAP, 0,0,0,0, 4'h0, 0,0,0,0,1), 0);
    do_reset("rst_after_fto");

    // 17 retires on a 4-bit counter: the next FETCH sees instret = 1.
    for (int n = 0; n < 17; n++) run_alu("wrap_add", I_ADD, 0, 4'b0000, 0);
    step("wrap_fetch", I_LW, 1, 0, 0, mk(S_FETCH, 1,0,0,0, 4'h0, 0,0,0,0,0), 0);

    // Reset mid-MEMORY: outputs drop immediately.
    step("mid_decode", I_LW, 1, 0, 0, mk(S_DECODE, 0,0,0,0, 4'h0, 0,0,0,0,0), 0);
    step("mid_ex", I_LW, 1, 0, 0, mk(S_EXECUTE, 0,0,0,1, ALU_ADD, 0,0,0,0,0), 0);
    step("mid_mwait", I_LW, 1, 0, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,1,0,0), 0);
    step("mid_mwait", I_LW, 1, 0, 0, mk(S_MEMORY, 0,0,0,0, 4'h0, 0,0,1,0,0), 0);
    do_reset("rst_mid_mem");
    run_alu("post_rst_add", I_ADD, 0, 4'b0000, 0);
    step("final_fetch", I_ADD, 0, 0, 0, mk(S_FETCH, 0,0,0,0, 4'h0, 0,0,0,0,0), 0);

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_hs.md
Name: multicycle_ctrl_hs

Overview:
- Second-generation multicycle RV32I control FSM; drives the existing datapath (PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC) and the instruction/data memories.
- Over the first generation it adds:
  - ready/valid handshakes to both memories, with a timeout;
  - BEQ/BNE resolution and illegal-instruction trap;
  - a sticky fault state;
  - a retired-instruction counter.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 16: maximum wait cycles for iReady/dReady before trapping (range 1..255).
- ALUC_W, 4: ALUCtrl width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  instruction held by datapath IR
- iReady  in  1  instruction memory has valid data this cycle
- dReady  in  1  data memory completed the read/write this cycle
- Zero  in  1  ALU zero flag
- irWrite  out  1  latch instr into IR
- PCSrc  out  1  0 = PC+4, 1 = branch target
- loadPC  out  1  PC update strobe
- ALUSrc  out  1  1 = immediate operand
- ALUCtrl  out  ALUC_W  ALU operation
- RegWrite  out  1  register-file write enable
- MemToReg  out  1  1 = writeback from dReadData
- MemRead  out  1  data memory read request
- MemWrite  out  1  data memory write request
- fault  out  1  sticky trap indication
- instret  out  CNT_W  instructions retired
- state_o  out  3  current state, for debug

Behaviour:
- Reset:
  - state = FETCH; wait counter = 0; instret = 0; fault = 0.
  - All control outputs are forced to 0 while rst is high.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITE_BACK, TRAP.
- Control outputs are combinational from state, instr, Zero, iReady and dReady. Default for every output is 0.
- FETCH:
  - irWrite = iReady.
  - iReady = 1 -> DECODE.
  - Otherwise stay and increment the wait counter; counter reaching MEMORY_TIMEOUT... reaching MEM_TIMEOUT -> TRAP.
  - The wait counter clears on every state change.
- DECODE:
  - Legal opcodes: 0110011 (R-type), 0010011 (I-type), 0000011 (LW, funct3 = 010), 0100011 (SW, funct3 = 010), 1100011 (branch, funct3 000/001).
  - Legal -> EXECUTE; anything else -> TRAP.
- EXECUTE, ALUCtrl / ALUSrc by class:
  - R-type: ALUCtrl = {instr[30], funct3}, ALUSrc = 0.
  - I-type: ALUCtrl = {funct3 == 101 ? instr[30] : 0, funct3}, ALUSrc = 1.
  - LW/SW: ALUCtrl = ALU_ADD, ALUSrc = 1.
  - Branch: ALUCtrl = ALU_SUB, ALUSrc = 0; PCSrc = Zero XOR funct3[0]; loadPC = 1.
- EXECUTE, next state:
  - Branch -> FETCH, retiring the instruction.
  - LW/SW -> MEMORY.
  - Others -> WRITE_BACK.
- MEMORY:
  - LW: MemRead = 1 held until dReady.
  - SW: MemWrite = 1 held until dReady.
  - SW with dReady -> FETCH; loadPC = 1, PCSrc = 0; retire.
  - LW with dReady -> WRITE_BACK.
  - No dReady: wait count; reaching MEM_TIMEOUT -> TRAP. MemRead/MemWrite drop in TRAP.
- WRITE_BACK:
  - RegWrite = 1; MemToReg = (opcode == LW); loadPC = 1, PCSrc = 0; retire; -> FETCH.
  - One cycle only.
- Latencies with zero-wait memories:
  - Branch: 3 cycles.
  - ALU: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
- Retire:
  - instret += 1 on the retiring clock edge.
  - Wraps modulo 2^CNT_W with no saturation.
- TRAP:
  - fault = 1; all other controls 0; loadPC never asserted.
  - Exit only via rst; rst mid-wait or mid-trap returns to the reset values.
- Simultaneous events: dReady arriving on the same cycle the counter would hit MEM_TIMEOUT counts as success; the handshake takes priority.
- Writes to rd = x0 are allowed; the register file ignores them.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding;
  - opcode constants (OP_R, OP_I, OP_LW, OP_SW, OP_BR);
  - ALU_ADD = 4'b0000 and ALU_SUB = 4'b1000.
- One sub-module, wait_timer: loadable counter with clear, enable, and an expired flag at MEM_TIMEOUT. It is reused for both the FETCH and MEMORY waits.

Test Plan:
- Reset then `add x3,x1,x2` (0x002081B3) with iReady held 1:
  - state sequence FETCH, DECODE, EXECUTE, WRITE_BACK;
  - ALUCtrl = 0000;
  - RegWrite = 1 and loadPC = 1 only in cycle 4;
  - instret = 1.
- `lw x5,8(x0)` with dReady delayed 3 cycles:
  - MemRead is high for 4 cycles;
  - then WRITE_BACK with MemToReg = 1;
  - total 8 cycles; instret increments once.
- `beq` with Zero = 1, then `bne` with Zero = 1:
  - first: PCSrc = 1, loadPC = 1 in EXECUTE;
  - second: PCSrc = 0;
  - each takes 3 cycles.
- Illegal opcode 0x0000007F:
  - DECODE -> TRAP; fault = 1;
  - no loadPC or RegWrite afterwards;
  - rst clears fault and returns to FETCH.
- `sw` with dReady never asserted and MEM_TIMEOUT = 16:
  - TRAP entered exactly 16 cycles after entering MEMORY;
  - MemWrite = 0 in TRAP.
  - Rerun with dReady on cycle 16: SW retires instead of trapping.
- CNT_W = 4: retire 17 instructions -> instret = 1 (wrap). Assert rst mid-MEMORY -> all outputs 0 immediately.
